gnt_burst_mux: RTL and testbench
================================

Name: gnt_burst_mux

Overview:
Downstream consumer of the round-robin arbiter's one-hot grant. Latches the granted requester as burst owner and moves that requester's data beats through a one-entry registered valid/ready output stage until the burst ends. Drives lock_o back to the arbiter so the grant stays frozen mid-burst.

Parameters:
NUM_REQUESTERS, 2, number of requesters; must match the arbiter; at least 1
DATA_W, 8, data width per requester
MAX_BURST, 4, maximum beats per burst; at least 1
TIMEOUT_CYC, 8, stall limit in cycles; used only with GNT_BURST_TIMEOUT_EN

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset
gnt_i  in  NUM_REQUESTERS  one-hot grant from the arbiter
req_valid_i  in  NUM_REQUESTERS  per-requester beat valid
req_data_i  in  NUM_REQUESTERS*DATA_W  packed data; requester k occupies bits [k*DATA_W +: DATA_W]
req_last_i  in  NUM_REQUESTERS  per-requester last-beat flag
req_ready_o  out  NUM_REQUESTERS  per-requester beat accept
out_valid_o  out  1  output beat valid
out_data_o  out  DATA_W  output beat data
out_src_o  out  SRC_W  index of the owner that produced the beat; SRC_W = (NUM_REQUESTERS>1) ? $clog2(NUM_REQUESTERS) : 1
out_last_o  out  1  final beat of the burst
out_ready_i  in  1  downstream accept
lock_o  out  1  burst in progress; arbiter must hold its grant
err_gnt_o  out  1  sticky flag: a grant with more than one bit set was seen

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. out_valid_o, out_last_o, lock_o, err_gnt_o, beat count all 0. out_data_o 0, out_src_o 0. req_ready_o combinationally 0.
- Beat accept: accept = req_valid_i[owner] & req_ready_o[owner].
- Output drain: drain = out_valid_o & out_ready_i.
- State IDLE:
  - lock_o=0; req_ready_o all 0.
  - gnt_i exactly one-hot at bit k: owner<=k, state<=BURST, lock_o=1 from the next cycle. No beat is accepted in the capture cycle.
  - gnt_i=0: stay in IDLE.
  - gnt_i with popcount>1: stay in IDLE, set err_gnt_o (cleared only by reset).
- State BURST:
  - lock_o=1. gnt_i is ignored.
  - req_ready_o[owner] = !out_valid_o | out_ready_i; all other ready bits are 0.
  - On accept: output register loads data[owner], out_src_o<=owner, out_last_o<=(req_last_i[owner] | count==MAX_BURST-1), out_valid_o<=1, count<=count+1.
  - Latency: one cycle from accept to out_valid_o.
  - drain without accept: out_valid_o<=0.
  - drain and accept in the same cycle: register reloads, giving full throughput of 1 beat per cycle.
  - Accept of the terminating beat (last=1, or count reaches MAX_BURST): state<=IDLE, count<=0, lock_o=0 next cycle.
  - The terminating beat may still sit in the output register after returning to IDLE; it drains normally.
  - A new owner captured in IDLE cannot accept until the output register frees, by the ready rule above.
- Beat counter width: $clog2(MAX_BURST+1). It never wraps; forced termination at MAX_BURST.
- out_valid_o, out_data_o, out_src_o and out_last_o hold stable while out_valid_o=1 & out_ready_i=0.

Optional Feature:
GNT_BURST_TIMEOUT_EN
- Defined:
  - In BURST, a stall counter increments each cycle req_valid_i[owner]=0 and clears on accept.
  - Reaching TIMEOUT_CYC aborts the burst: state<=IDLE, lock_o=0 next cycle.
  - The stall is reported as a one-cycle pulse on an extra output port timeout_o. No synthetic last beat is emitted.
- Undefined: no stall counter and no timeout_o port. BURST waits indefinitely for the owner.

Test Plan:
- Reset mid-burst: N=2, burst in flight with out_valid_o=1, assert reset=0 asynchronously -> out_valid_o, lock_o and req_ready_o drop immediately; state IDLE after release.
- Basic burst: gnt_i=2'b10, requester 1 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), out_ready_i=1 -> out_data_o 0xA1..0xA3 on consecutive cycles, each one cycle after accept; out_src_o=1; out_last_o on 0xA3 only; lock_o high from the cycle after capture until the cycle after the 0xA3 accept.
- MAX_BURST cut: MAX_BURST=4, requester 0 sends 6 beats with last never set -> only 4 beats accepted; 4th beat has out_last_o=1; FSM returns to IDLE; lock_o=0.
- Backpressure: out_ready_i=0 for 3 cycles mid-burst -> req_ready_o[owner]=0; output held stable; no beat lost or duplicated after out_ready_i returns to 1.
- Grant change and bad grant: gnt_i switches 01->10 during a BURST owned by requester 0 -> ignored, out_src_o stays 0. Later gnt_i=2'b11 in IDLE -> no capture, err_gnt_o=1 until reset.
- Timeout (GNT_BURST_TIMEOUT_EN, TIMEOUT_CYC=8): owner drops valid after 1 beat -> timeout_o pulses after 8 idle cycles; lock_o falls the next cycle.

Source files
------------

// File: rtl/gnt_burst_mux.sv
// gnt_burst_mux: latches the arbiter's one-hot grant as burst owner and
// forwards the owner's beats through a one-entry registered output stage.
// Ports: clk, reset (async, active-low); gnt_i one-hot grant;
//   req_valid_i/req_data_i/req_last_i -> req_ready_o per requester;
//   out_valid_o/out_data_o/out_src_o/out_last_o <- out_ready_i;
//   lock_o holds the arbiter grant mid-burst; err_gnt_o sticky bad grant.
// Option GNT_BURST_TIMEOUT_EN: stall abort after TIMEOUT_CYC, timeout_o.
module gnt_burst_mux #(
  parameter int NUM_REQUESTERS = 2,
  parameter int DATA_W         = 8,
  parameter int MAX_BURST      = 4,
  parameter int TIMEOUT_CYC    = 8,
  localparam int SRC_W =
    (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQUESTERS-1:0]      gnt_i,
  input  logic [NUM_REQUESTERS-1:0]      req_valid_i,
  input  logic [NUM_REQUESTERS*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQUESTERS-1:0]      req_last_i,
  output logic [NUM_REQUESTERS-1:0]      req_ready_o,
  output logic                           out_valid_o,
  output logic [DATA_W-1:0]              out_data_o,
  output logic [SRC_W-1:0]               out_src_o,
  output logic                           out_last_o,
  input  logic                           out_ready_i,
  output logic                           lock_o,
`ifdef GNT_BURST_TIMEOUT_EN
  output logic                           timeout_o,
`endif
  output logic                           err_gnt_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t state, next_state;

  logic [SRC_W-1:0]  owner;
  logic [SRC_W-1:0]  gnt_idx;
  logic [CNT_W-1:0]  count;
  logic              gnt_any;
  logic              gnt_multi;
  logic              gnt_ok;
  logic              slot_free;
  logic              accept;
  logic              term;
  logic              abort;
  logic              own_valid;
  logic              own_last;
  logic [DATA_W-1:0] own_data;

  assign gnt_any   = |gnt_i;
  // x & (x-1) clears the lowest set bit; non-zero means two or more bits
  assign gnt_multi = |(gnt_i & (gnt_i - NUM_REQUESTERS'(1)));
  assign gnt_ok    = gnt_any & ~gnt_multi;

  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      if (gnt_i[k]) gnt_idx = SRC_W'(k);
    end
  end

  assign own_valid = req_valid_i[owner];
  assign own_last  = req_last_i[owner];
  assign own_data  = req_data_i[int'(owner)*DATA_W +: DATA_W];
  // The output slot can take a beat if empty or draining this cycle
  assign slot_free = ~out_valid_o | out_ready_i;

`ifdef GNT_BURST_TIMEOUT_EN
  localparam int STL_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(TIMEOUT_CYC - 1);

  logic [STL_W-1:0] stall;

  assign abort = (state == BURST) & ~own_valid & (stall == STL_LAST);
  assign timeout_o = abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall <= '0;
    end else if (state != BURST || accept || abort) begin
      stall <= '0;
    end else if (!own_valid) begin
      stall <= stall + STL_W'(1);
    end
  end
`else
  wire unused_tmo = |TIMEOUT_CYC;
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    req_ready_o = '0;
    lock_o      = 1'b0;
    accept      = 1'b0;
    term        = 1'b0;
    unique case (state)
      IDLE: begin
        if (gnt_ok) next_state = BURST;
      end
      BURST: begin
        lock_o             = 1'b1;
        req_ready_o[owner] = slot_free;
        accept             = own_valid & slot_free;
        term = accept & (own_last | (count == CNT_LAST));
        if (term || abort) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner     <= '0;
      count     <= '0;
      err_gnt_o <= 1'b0;
    end else begin
      if (state == IDLE && gnt_ok) owner <= gnt_idx;
      if (state == IDLE && gnt_multi) err_gnt_o <= 1'b1;
      if (term || abort) begin
        count <= '0;
      end else if (accept) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_src_o   <= '0;
      out_last_o  <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      out_data_o  <= own_data;
      out_src_o   <= owner;
      out_last_o  <= own_last | (count == CNT_LAST);
    end else if (out_valid_o && out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gnt_burst_mux.sv
// tb_gnt_burst_mux: directed vectors for gnt_burst_mux (N=2, W=8, MAX=4).
// Covers reset, bursts, max-length cut, backpressure, grants, timeout.
module tb_gnt_burst_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  gnt;
  logic [1:0]  valid;
  logic [15:0] data;
  logic [1:0]  last;
  logic [1:0]  ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [0:0]  out_src;
  logic        out_last;
  logic        out_ready;
  logic        lock;
  logic        err;
`ifdef GNT_BURST_TIMEOUT_EN
  logic        timeout;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  gnt_burst_mux #(
    .NUM_REQUESTERS(2),
    .DATA_W(8),
    .MAX_BURST(4),
    .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .gnt_i(gnt),
    .req_valid_i(valid),
    .req_data_i(data),
    .req_last_i(last),
    .req_ready_o(ready),
    .out_valid_o(out_valid),
    .out_data_o(out_data),
    .out_src_o(out_src),
    .out_last_o(out_last),
    .out_ready_i(out_ready),
    .lock_o(lock),
`ifdef GNT_BURST_TIMEOUT_EN
    .timeout_o(timeout),
`endif
    .err_gnt_o(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_req();
    valid = '0;
    last  = '0;
    data  = '0;
  endtask

  task automatic beat(input int k, input logic [7:0] d,
                      input logic l);
    idle_req();
    valid[k]       = 1'b1;
    data[k*8 +: 8] = d;
    last[k]        = l;
  endtask

  initial begin
    rst_n     = 1'b0;
    gnt       = '0;
    out_ready = 1'b1;
    idle_req();
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_lock", lock, 0);
    check("rst_err", err, 0);
    check("rst_data", out_data, 0);
    check("rst_src", out_src, 0);
    check("rst_ready", ready, 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // basic burst from requester 1
    gnt = 2'b10;
    #1;
    check("b_idle_lock", lock, 0);
    check("b_idle_rdy", ready, 0);
    cyc();
    gnt = '0;
    beat(1, 8'hA1, 1'b0);
    #1;
    check("b_lock", lock, 1);
    check("b_rdy", ready, 2'b10);
    cyc();
    check("b_v1", out_valid, 1);
    check("b_d1", out_data, 8'hA1);
    check("b_s1", out_src, 1);
    check("b_l1", out_last, 0);
    beat(1, 8'hA2, 1'b0);
    cyc();
    check("b_d2", out_data, 8'hA2);
    check("b_l2", out_last, 0);
    check("b_lock2", lock, 1);
    beat(1, 8'hA3, 1'b1);
    cyc();
    check("b_d3", out_data, 8'hA3);
    check("b_l3", out_last, 1);
    check("b_v3", out_valid, 1);
    check("b_unlock", lock, 0);
    idle_req();
    cyc();
    check("b_drain", out_valid, 0);

    // MAX_BURST cut, requester 0, last never set
    gnt = 2'b01;
    cyc();
    gnt = '0;
    for (int i = 0; i < 6; i++) begin
      beat(0, 8'(8'hB0 + i), 1'b0);
      cyc();
      if (i < 4) begin
        check("m_valid", out_valid, 1);
        check("m_data", out_data, 8'hB0 + i);
        check("m_last", out_last, (i == 3));
        check("m_lock", lock, (i < 3));
      end else begin
        check("m_extra", out_valid, 0);
        check("m_lock_idle", lock, 0);
        check("m_rdy_idle", ready, 0);
      end
    end
    idle_req();

    // backpressure, requester 1
    gnt = 2'b10;
    cyc();
    gnt = '0;
    beat(1, 8'hC0, 1'b0);
    cyc();
    check("p_d0", out_data, 8'hC0);
    out_ready = 1'b0;
    beat(1, 8'hC1, 1'b0);
    #1;
    check("p_rdy_stall", ready, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("p_hold_v", out_valid, 1);
      check("p_hold_d", out_data, 8'hC0);
      check("p_hold_s", out_src, 1);
      check("p_hold_r", ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check("p_rdy_back", ready, 2'b10);
    cyc();
    check("p_d1", out_data, 8'hC1);
    beat(1, 8'hC2, 1'b0);
    cyc();
    check("p_d2", out_data, 8'hC2);
    beat(1, 8'hC3, 1'b1);
    cyc();
    check("p_d3", out_data, 8'hC3);
    check("p_l3", out_last, 1);
    idle_req();
    cyc();
    check("p_drain", out_valid, 0);

    // grant switches mid-burst, then a bad grant
    gnt = 2'b01;
    cyc();
    gnt = 2'b10;
    beat(0, 8'hD0, 1'b0);
    #1;
    check("g_rdy_owner", ready, 2'b01);
    cyc();
    check("g_d0", out_data, 8'hD0);
    check("g_s0", out_src, 0);
    check("g_lock", lock, 1);
    beat(0, 8'hD1, 1'b1);
    cyc();
    check("g_d1", out_data, 8'hD1);
    check("g_s1", out_src, 0);
    check("g_l1", out_last, 1);
    gnt = '0;
    idle_req();
    cyc();
    check("g_drain", out_valid, 0);
    check("g_idle", lock, 0);
    gnt = 2'b11;
    cyc();
    check("g_err", err, 1);
    check("g_nocap", lock, 0);
    gnt = '0;
    cyc();
    check("g_err_sticky", err, 1);
    check("g_still_idle", lock, 0);

`ifdef GNT_BURST_TIMEOUT_EN
    // owner stalls after one beat
    gnt = 2'b01;
    cyc();
    gnt = '0;
    beat(0, 8'hF0, 1'b0);
    cyc();
    check("t_d0", out_data, 8'hF0);
    idle_req();
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t_pulse", timeout, (i == 7));
      check("t_lock", lock, 1);
      cyc();
    end
    #1;
    check("t_unlock", lock, 0);
    check("t_pulse_end", timeout, 0);
`endif

    // asynchronous reset mid-burst
    gnt = 2'b01;
    cyc();
    gnt = '0;
    out_ready = 1'b0;
    beat(0, 8'hE0, 1'b0);
    cyc();
    check("r_v", out_valid, 1);
    check("r_d", out_data, 8'hE0);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_valid_drop", out_valid, 0);
    check("r_lock_drop", lock, 0);
    check("r_rdy_drop", ready, 0);
    check("r_err_clr", err, 0);
    check("r_data_clr", out_data, 0);
    #1;
    rst_n = 1'b1;
    cyc();
    check("r_idle_lock", lock, 0);
    check("r_idle_rdy", ready, 0);
    cyc();
    check("r_idle_v", out_valid, 0);
    out_ready = 1'b1;
    idle_req();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
